// File: rtl/fmps_test_link_checker.sv
// FMPS test-link receive checker: framing, payload and FA-cycle statistics.
// Optional errorCount statistics enabled by defining FMPS_CHECKER_STATS_EN.
module fmps_test_link_checker #(
   parameter int          INDEX_WIDTH     = 5,
   parameter int          INDEX_START_BIT = 10,
   parameter logic [15:0] HEADER_MAGIC    = 16'hB6CF,
   parameter logic [15:0] DATA_MAGIC      = 16'hCACA,
   parameter int          NUM_DATA_WORDS  = 1
) (
   input  logic                         auroraUserClk,
   input  logic                         auroraReset,
   input  logic                         auroraChannelUp,
   input  logic                         auroraFAstrobe,
   input  logic [31:0]                  RX_tdata,
   input  logic                         RX_tvalid,
   input  logic                         RX_tlast,
   output logic                         packetStrobe,
   output logic [INDEX_WIDTH-1:0]       packetIndex,
   output logic [32*NUM_DATA_WORDS-1:0] packetData,
   output logic                         statusStrobe,
   output logic [2:0]                   statusCode,
   output logic [7:0]                   cyclePacketCount,
   output logic [7:0]                   expectedCycle,
   output logic [15:0]                  errorCount
);

   localparam int         DW        = 32*NUM_DATA_WORDS;
   localparam logic [1:0] LAST_WORD = 2'(NUM_DATA_WORDS-1);

   localparam logic [2:0] ST_OK      = 3'd0;
   localparam logic [2:0] ST_MAGIC   = 3'd1;
   localparam logic [2:0] ST_SHORT   = 3'd2;
   localparam logic [2:0] ST_LONG    = 3'd3;
   localparam logic [2:0] ST_PAYLOAD = 3'd4;

   typedef enum logic [1:0] {
      HEADER = 2'd0,
      DATA   = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   state_t                 state;
   state_t                 stateNext;
   logic [1:0]             wordCnt;
   logic [1:0]             wordCntNext;
   logic [INDEX_WIDTH-1:0] pktIdx;
   logic [DW-1:0]          dataBuf;
   logic [DW-1:0]          pktWords;
   logic [31:0]            chkWord;
   logic                   payloadOk;
   logic                   capHeader;
   logic                   storeWord;
   logic                   stsValid;
   logic [2:0]             stsCode;
   logic                   goodNow;
   logic [7:0]             pktCnt;
   logic [7:0]             pktCntInc;

   // Packet as it will look once the current word lands in the buffer
   always_comb begin
      pktWords  = dataBuf;
      for (int i = 0; i < NUM_DATA_WORDS; i++) begin
         if (wordCnt == 2'(i)) begin
            pktWords[i*32 +: 32] = RX_tdata;
         end
      end
      payloadOk = 1'b1;
      chkWord   = '0;
      for (int i = 0; i < NUM_DATA_WORDS; i++) begin
         chkWord = pktWords[i*32 +: 32];
         if (chkWord[31:29] != 3'b000 ||
             chkWord[28:24] != 5'(pktIdx) ||
             chkWord[23:8]  != DATA_MAGIC ||
             chkWord[7:0]   != expectedCycle) begin
            payloadOk = 1'b0;
         end
      end
   end

   always_comb begin
      stateNext   = state;
      wordCntNext = wordCnt;
      capHeader   = 1'b0;
      storeWord   = 1'b0;
      stsValid    = 1'b0;
      stsCode     = ST_OK;
      goodNow     = 1'b0;
      if (!auroraChannelUp) begin
         stateNext   = HEADER;
         wordCntNext = '0;
      end else if (RX_tvalid) begin
         unique case (state)
            HEADER: begin
               capHeader   = 1'b1;
               wordCntNext = '0;
               if (RX_tdata[31:16] != HEADER_MAGIC) begin
                  stsValid  = 1'b1;
                  stsCode   = ST_MAGIC;
                  stateNext = RX_tlast ? HEADER : DRAIN;
               end else if (RX_tlast) begin
                  stsValid = 1'b1;
                  stsCode  = ST_SHORT;
               end else begin
                  stateNext = DATA;
               end
            end
            DATA: begin
               storeWord = 1'b1;
               if (wordCnt != LAST_WORD) begin
                  if (RX_tlast) begin
                     stsValid    = 1'b1;
                     stsCode     = ST_SHORT;
                     stateNext   = HEADER;
                     wordCntNext = '0;
                  end else begin
                     wordCntNext = wordCnt + 2'd1;
                  end
               end else if (!RX_tlast) begin
                  stsValid    = 1'b1;
                  stsCode     = ST_LONG;
                  stateNext   = DRAIN;
                  wordCntNext = '0;
               end else begin
                  stsValid    = 1'b1;
                  stateNext   = HEADER;
                  wordCntNext = '0;
                  if (payloadOk) begin
                     goodNow = 1'b1;
                  end else begin
                     stsCode = ST_PAYLOAD;
                  end
               end
            end
            DRAIN: begin
               if (RX_tlast) begin
                  stateNext = HEADER;
               end
            end
            default: begin
               stateNext   = HEADER;
               wordCntNext = '0;
            end
         endcase
      end
   end

   always_ff @(posedge auroraUserClk) begin
      if (auroraReset) begin
         state   <= HEADER;
         wordCnt <= '0;
      end else begin
         state   <= stateNext;
         wordCnt <= wordCntNext;
      end
   end

   // A good packet closing on the FA strobe belongs to the closing cycle
   assign pktCntInc = (goodNow && pktCnt != 8'hFF) ? pktCnt + 8'd1 : pktCnt;

   always_ff @(posedge auroraUserClk) begin
      if (auroraReset) begin
         pktIdx           <= '0;
         dataBuf          <= '0;
         packetStrobe     <= 1'b0;
         packetIndex      <= '0;
         packetData       <= '0;
         statusStrobe     <= 1'b0;
         statusCode       <= '0;
         cyclePacketCount <= '0;
         expectedCycle    <= '0;
         pktCnt           <= '0;
      end else begin
         statusStrobe <= stsValid;
         packetStrobe <= goodNow;
         if (capHeader) begin
            pktIdx <= RX_tdata[INDEX_START_BIT +: INDEX_WIDTH];
         end
         if (storeWord) begin
            dataBuf <= pktWords;
         end
         if (stsValid) begin
            statusCode <= stsCode;
         end
         if (goodNow) begin
            packetIndex <= pktIdx;
            packetData  <= pktWords;
         end
         if (auroraFAstrobe) begin
            expectedCycle    <= expectedCycle + 8'd1;
            cyclePacketCount <= pktCntInc;
            pktCnt           <= '0;
         end else begin
            pktCnt <= pktCntInc;
         end
      end
   end

`ifdef FMPS_CHECKER_STATS_EN
   always_ff @(posedge auroraUserClk) begin
      if (auroraReset) begin
         errorCount <= '0;
      end else if (stsValid && stsCode != ST_OK &&
                   errorCount != 16'hFFFF) begin
         errorCount <= errorCount + 16'd1;
      end
   end
`else
   assign errorCount = '0;
`endif

endmodule
